onehot_scan_decoder: RTL and testbench

- Parametrised, registered successor to the team's combinational 2-to-4 decoder: SEL_W-bit index decoded to a 2^SEL_W one-hot output.
- Two modes:
  - Direct: an index is loaded on request.
  - Scan: an internal counter walks the outputs with a programmable dwell time.
- Sits in front of multiplexed display/row-select logic and chip-select fan-out. Replaces per-width hand-written decoders.

---
 rtl/onehot_dec_pkg.sv | 15 +
 rtl/onehot_scan_decoder_dwell_counter.sv | 36 +++
 rtl/onehot_scan_decoder.sv | 121 ++++++++++++
 tb/tb_onehot_scan_decoder.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/onehot_dec_pkg.sv
// Shared types, mode encodings and the one-hot helper for onehot_scan_decoder.
package onehot_dec_pkg;

  localparam int MAX_SEL_W = 8;
  localparam int MAX_OUT_W = 2 ** MAX_SEL_W;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Callers truncate the result to their own output width.
  function automatic logic [MAX_OUT_W-1:0] onehot(input int unsigned idx);
    return MAX_OUT_W'(1) << idx;
  endfunction

endpackage

// File: rtl/onehot_scan_decoder_dwell_counter.sv
// Modulo-DWELL counter with clear, hold and terminal-count flag.
module dwell_counter #(
  parameter int DWELL = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic tc
);

  localparam int CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] cnt_d, cnt_q;

  assign tc = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = tc ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/onehot_scan_decoder.sv
// Registered SEL_W-to-2^SEL_W one-hot decoder with direct and scan modes.
// Define SCAN_BLANK_EN for a blank cycle on every scan advance.
module onehot_scan_decoder
  import onehot_dec_pkg::*;
#(
  parameter int SEL_W = 2,
  parameter int DWELL = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  load,
  input  logic [SEL_W-1:0]      sel_in,
  output logic [2**SEL_W-1:0]   y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      idx,
  output logic                  scan_wrap
);

  localparam int OUT_W = 2 ** SEL_W;

  if (SEL_W < 1 || SEL_W > MAX_SEL_W) begin : g_bad_sel_w
    $error("SEL_W out of range");
  end
  if (DWELL < 1 || DWELL > 65535) begin : g_bad_dwell
    $error("DWELL out of range 1..65535");
  end
`ifdef SCAN_BLANK_EN
  if (DWELL == 1) begin : g_bad_blank
    $error("SCAN_BLANK_EN requires DWELL > 1");
  end
`endif

  logic [SEL_W-1:0] idx_d, idx_q, idx_nxt;
  logic [OUT_W-1:0] y_d, y_q;
  logic [OUT_W-1:0] hot_idx, hot_sel, hot_nxt;
  logic             y_valid_d, y_valid_q;
  logic             wrap_d, wrap_q;
  logic             mode_d, mode_q;
  logic             scan_act, entry;
  logic             cnt_clr, cnt_inc, cnt_tc, adv;

  assign idx_nxt = idx_q + SEL_W'(1);
  assign hot_idx = OUT_W'(onehot(32'(idx_q)));
  assign hot_sel = OUT_W'(onehot(32'(sel_in)));
  assign hot_nxt = OUT_W'(onehot(32'(idx_nxt)));

  // mode_q remembers the last enabled mode, so entry into scan is seen once.
  assign scan_act = en && (mode == MODE_SCAN);
  assign entry    = scan_act && (mode_q == MODE_DIRECT);
  assign cnt_clr  = entry || (en && (mode == MODE_DIRECT) && load);
  assign cnt_inc  = scan_act && !entry;
  assign adv      = cnt_inc && cnt_tc;

  dwell_counter #(
    .DWELL(DWELL)
  ) u_dwell (
    .clk(clk),
    .rst(rst),
    .clr(cnt_clr),
    .inc(cnt_inc),
    .tc (cnt_tc)
  );

  always_comb begin
    idx_d     = idx_q;
    y_d       = y_q;
    y_valid_d = y_valid_q;
    wrap_d    = 1'b0;
    mode_d    = mode_q;
    if (!en) begin
      y_d       = '0;
      y_valid_d = 1'b0;
    end else begin
      mode_d = mode;
      if (mode == MODE_SCAN) begin
        if (adv) begin
          idx_d  = idx_nxt;
          wrap_d = &idx_q;
`ifdef SCAN_BLANK_EN
          y_d       = '0;
          y_valid_d = 1'b0;
`else
          y_d       = hot_nxt;
          y_valid_d = 1'b1;
`endif
        end else begin
          y_d       = hot_idx;
          y_valid_d = 1'b1;
        end
      end else if (load) begin
        idx_d     = sel_in;
        y_d       = hot_sel;
        y_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q     <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
      wrap_q    <= 1'b0;
      mode_q    <= MODE_DIRECT;
    end else begin
      idx_q     <= idx_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
      wrap_q    <= wrap_d;
      mode_q    <= mode_d;
    end
  end

  assign y         = y_q;
  assign y_valid   = y_valid_q;
  assign idx       = idx_q;
  assign scan_wrap = wrap_q;

endmodule

// File: tb/tb_onehot_scan_decoder.sv
// Self-checking bench for onehot_scan_decoder (SEL_W=2, DWELL=3).
module tb_onehot_scan_decoder;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic       mode;
  logic       load;
  logic [1:0] sel_in;
  logic [3:0] y;
  logic       y_valid;
  logic [1:0] idx;
  logic       scan_wrap;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    logic       rst;
    logic       en;
    logic       mode;
    logic       load;
    logic [1:0] sel;
    logic [3:0] y;
    logic       v;
    logic [1:0] idx;
    logic       wrap;
  } vec_t;

  typedef struct {
    logic [3:0] y;
    logic       v;
    logic [1:0] idx;
    logic       wrap;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  onehot_scan_decoder #(
    .SEL_W(2),
    .DWELL(3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load     (load),
    .sel_in   (sel_in),
    .y        (y),
    .y_valid  (y_valid),
    .idx      (idx),
    .scan_wrap(scan_wrap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: timeout, run did not complete");
    $fatal(1, "timeout");
  end

  task automatic v(input logic r, input logic e, input logic m,
                   input logic l, input logic [1:0] s,
                   input logic [3:0] ey, input logic ev,
                   input logic [1:0] ei, input logic ew);
    vec_t t;
    t.rst = r; t.en = e; t.mode = m; t.load = l; t.sel = s;
    t.y = ey; t.v = ev; t.idx = ei; t.wrap = ew;
    tbl.push_back(t);
  endtask

  task automatic check(input string name, input exp_t e);
    n_chk++;
    if (y !== e.y || y_valid !== e.v || idx !== e.idx
        || scan_wrap !== e.wrap) begin
      n_fail++;
      $display("FAIL %s: got y=%b v=%b idx=%0d wrap=%b, want y=%b v=%b idx=%0d wrap=%b",
               name, y, y_valid, idx, scan_wrap, e.y, e.v, e.idx, e.wrap);
    end
  endtask

  task automatic push(input logic [3:0] ey, input logic ev,
                      input logic [1:0] ei, input logic ew);
    exp_t e;
    e.y = ey; e.v = ev; e.idx = ei; e.wrap = ew;
    sb.push_back(e);
  endtask

  task automatic pop_check(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: scoreboard empty, got y=%b want an entry", name, y);
    end else begin
      e = sb.pop_front();
      check(name, e);
    end
  endtask

  initial begin
    exp_t z;
    z.y = '0; z.v = 1'b0; z.idx = '0; z.wrap = 1'b0;

    // direct mode, loads, hold, enable gating
    v(0,1,0,0,0, 4'b0000,0,0,0);
    v(0,1,0,1,2, 4'b0100,1,2,0);
    repeat (5) v(0,1,0,0,1, 4'b0100,1,2,0);
    v(0,1,0,1,3, 4'b1000,1,3,0);
    v(0,1,0,1,0, 4'b0001,1,0,0);
    v(0,0,0,1,2, 4'b0000,0,0,0);
    v(0,1,0,0,0, 4'b0000,0,0,0);
    v(0,1,0,1,1, 4'b0010,1,1,0);
    // mode and load on the same edge: mode wins, full dwell on idx 1
    v(0,1,1,1,3, 4'b0010,1,1,0);
    repeat (2) v(0,1,1,0,0, 4'b0010,1,1,0);
    repeat (2) v(0,1,1,0,0, 4'b0100,1,2,0);
    // back to direct freezes y
    repeat (2) v(0,1,0,0,0, 4'b0100,1,2,0);
    repeat (3) v(0,1,1,0,0, 4'b0100,1,2,0);
    repeat (3) v(0,1,1,0,0, 4'b1000,1,3,0);
    v(0,1,1,0,0, 4'b0001,1,0,1);
    repeat (2) v(0,1,1,0,0, 4'b0001,1,0,0);
    v(0,1,1,0,0, 4'b0010,1,1,0);
    // enable dropped after one dwell cycle on idx 1
    repeat (4) v(0,0,1,0,0, 4'b0000,0,1,0);
    repeat (2) v(0,1,1,0,0, 4'b0010,1,1,0);
    v(0,1,1,0,0, 4'b0100,1,2,0);
    // reset, then full scan from idx 0
    v(1,0,0,0,0, 4'b0000,0,0,0);
    repeat (3) v(0,1,1,0,0, 4'b0001,1,0,0);
    repeat (3) v(0,1,1,0,0, 4'b0010,1,1,0);
    repeat (3) v(0,1,1,0,0, 4'b0100,1,2,0);
    repeat (3) v(0,1,1,0,0, 4'b1000,1,3,0);
    v(0,1,1,0,0, 4'b0001,1,0,1);
    v(0,1,1,0,0, 4'b0001,1,0,0);

    rst = 1'b1; en = 1'b0; mode = 1'b0; load = 1'b0; sel_in = '0;
    #1;
    check("reset_state", z);

    foreach (tbl[i]) begin
      rst    = tbl[i].rst;
      en     = tbl[i].en;
      mode   = tbl[i].mode;
      load   = tbl[i].load;
      sel_in = tbl[i].sel;
      push(tbl[i].y, tbl[i].v, tbl[i].idx, tbl[i].wrap);
      @(posedge clk);
      #1;
      pop_check($sformatf("vec%0d", i));
    end

    // async reset between edges while scanning at idx 3
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0; en = 1'b1; mode = 1'b1; load = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
    end
    push(4'b1000, 1'b1, 2'd3, 1'b0);
    pop_check("scan_at_idx3");
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_immediate", z);
    @(posedge clk);
    #1;
    check("rst_held_over_edge", z);
    rst = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      logic [1:0] ei;
      ei = 2'((k - 1) / 3);
      push(4'(1 << ei), 1'b1, ei, 1'b0);
      @(posedge clk);
      #1;
      pop_check($sformatf("post_rst_scan%0d", k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
